// File: rtl/hardroc_readout_ctrl.sv
// HARDROC readout controller.
// Fires the ASIC readout strobe on a sequencer request, waits (optionally bounded) for TRANSMITON,
// packs the serial DOUT stream MSB-first into DATA_WIDTH-bit words for the USB FIFO, flushes a
// trailing partial word left-aligned, and closes with a single-cycle EndReadout pulse.
module hardroc_readout_ctrl #(
    parameter int DATA_WIDTH      = 16,
    parameter int START_PULSE_LEN = 4
) (
    input  logic                  Clk,
    input  logic                  reset_n,
    input  logic                  StartReadout,
    input  logic                  TRANSMITON,
    input  logic                  DOUT,
    input  logic                  FifoFull,
    input  logic [15:0]           TimeoutCycles,
    output logic                  START_READOUT,
    output logic                  EndReadout,
    output logic [DATA_WIDTH-1:0] ParallelData,
    output logic                  ParallelDataValid,
    output logic [15:0]           WordCount,
    output logic                  ReadoutTimeout,
    output logic                  FifoOverflow
);

    // Bit counter must hold DATA_WIDTH itself for the left-align shift amount.
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam int PW = $clog2(START_PULSE_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_WAIT_TX = 3'd2,
        S_SHIFT   = 3'd3,
        S_FLUSH   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   shreg_q;
    logic [BW-1:0]           bitcnt_q;
    logic [PW-1:0]           pulse_q;
    logic [15:0]             tmo_q;
    logic                    start_readout_q;
    logic                    end_readout_q;
    logic [DATA_WIDTH-1:0]   pdata_q;
    logic                    pvalid_q;
    logic [15:0]             wcount_q;
    logic                    timeout_q;
    logic                    overflow_q;

    logic [DATA_WIDTH-1:0]   shift_word_s;
    logic                    word_done_s;
    logic                    flush_s;
    logic                    emit_s;
    logic [DATA_WIDTH-1:0]   emit_word_s;
    logic [15:0]             wcount_inc_s;
    logic [15:0]             tmo_next_s;

    // Move a partial word of n valid LSBs up to the MSB end, zero-filling below.
    function automatic logic [DATA_WIDTH-1:0] left_align(input logic [DATA_WIDTH-1:0] w,
                                                         input logic [BW-1:0]         n);
        logic [BW-1:0] sh;
        sh = BW'(DATA_WIDTH) - n;
        return w << sh;
    endfunction

    // Word assembly, emission decision and saturating counter increments.
    always_comb begin
        shift_word_s = {shreg_q[DATA_WIDTH-2:0], DOUT};
        word_done_s  = 1'b0;
        flush_s      = 1'b0;
        if (state_q == S_SHIFT) begin
            if (TRANSMITON) begin
                word_done_s = (bitcnt_q == BW'(DATA_WIDTH - 1));
            end else begin
                flush_s = (bitcnt_q != {BW{1'b0}});
            end
        end else begin
            word_done_s = 1'b0;
            flush_s     = 1'b0;
        end
        emit_s = word_done_s | flush_s;
        if (word_done_s) begin
            emit_word_s = shift_word_s;
        end else begin
            emit_word_s = left_align(shreg_q, bitcnt_q);
        end
        if (wcount_q == 16'hFFFF) begin
            wcount_inc_s = 16'hFFFF;
        end else begin
            wcount_inc_s = wcount_q + 16'd1;
        end
        if (tmo_q == 16'hFFFF) begin
            tmo_next_s = 16'hFFFF;
        end else begin
            tmo_next_s = tmo_q + 16'd1;
        end
    end

    // Readout sequencing FSM with all outputs registered.
    always_ff @(posedge Clk) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            shreg_q         <= {DATA_WIDTH{1'b0}};
            bitcnt_q        <= {BW{1'b0}};
            pulse_q         <= {PW{1'b0}};
            tmo_q           <= 16'd0;
            start_readout_q <= 1'b0;
            end_readout_q   <= 1'b0;
            pdata_q         <= {DATA_WIDTH{1'b0}};
            pvalid_q        <= 1'b0;
            wcount_q        <= 16'd0;
            timeout_q       <= 1'b0;
            overflow_q      <= 1'b0;
        end else begin
            pvalid_q      <= 1'b0;
            end_readout_q <= 1'b0;

            // A word is always presented on ParallelData; only the strobe and count depend on room.
            if (emit_s) begin
                pdata_q <= emit_word_s;
                if (!FifoFull) begin
                    pvalid_q <= 1'b1;
                    wcount_q <= wcount_inc_s;
                end else begin
                    overflow_q <= 1'b1;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (StartReadout) begin
                        state_q         <= S_START;
                        start_readout_q <= 1'b1;
                        pulse_q         <= {PW{1'b0}};
                        wcount_q        <= 16'd0;
                        timeout_q       <= 1'b0;
                        overflow_q      <= 1'b0;
                        shreg_q         <= {DATA_WIDTH{1'b0}};
                        bitcnt_q        <= {BW{1'b0}};
                        tmo_q           <= 16'd0;
                    end
                end
                S_START: begin
                    if (pulse_q == PW'(START_PULSE_LEN - 1)) begin
                        start_readout_q <= 1'b0;
                        tmo_q           <= 16'd0;
                        state_q         <= S_WAIT_TX;
                    end else begin
                        pulse_q <= pulse_q + PW'(1);
                    end
                end
                S_WAIT_TX: begin
                    if (TRANSMITON) begin
                        // The first TRANSMITON cycle already carries the first data bit.
                        shreg_q  <= shift_word_s;
                        bitcnt_q <= BW'(1);
                        state_q  <= S_SHIFT;
                    end else if ((TimeoutCycles != 16'd0) && (tmo_next_s == TimeoutCycles)) begin
                        timeout_q     <= 1'b1;
                        end_readout_q <= 1'b1;
                        state_q       <= S_DONE;
                    end else begin
                        tmo_q <= tmo_next_s;
                    end
                end
                S_SHIFT: begin
                    if (TRANSMITON) begin
                        shreg_q <= shift_word_s;
                        if (word_done_s) begin
                            bitcnt_q <= {BW{1'b0}};
                        end else begin
                            bitcnt_q <= bitcnt_q + BW'(1);
                        end
                    end else begin
                        // Any partial word is emitted by the shared emit path on this edge.
                        state_q <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    bitcnt_q      <= {BW{1'b0}};
                    end_readout_q <= 1'b1;
                    state_q       <= S_DONE;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    start_readout_q <= 1'b0;
                    state_q         <= S_IDLE;
                end
            endcase
        end
    end

    assign START_READOUT     = start_readout_q;
    assign EndReadout        = end_readout_q;
    assign ParallelData      = pdata_q;
    assign ParallelDataValid = pvalid_q;
    assign WordCount         = wcount_q;
    assign ReadoutTimeout    = timeout_q;
    assign FifoOverflow      = overflow_q;

endmodule

// File: tb/tb_hardroc_readout_ctrl.sv
// Directed, table-driven bench for hardroc_readout_ctrl.
module tb_hardroc_readout_ctrl;

    logic        Clk;
    logic        reset_n;
    logic        StartReadout;
    logic        TRANSMITON;
    logic        DOUT;
    logic        FifoFull;
    logic [15:0] TimeoutCycles;
    logic        START_READOUT;
    logic        EndReadout;
    logic [15:0] ParallelData;
    logic        ParallelDataValid;
    logic [15:0] WordCount;
    logic        ReadoutTimeout;
    logic        FifoOverflow;

    int total = 0;
    int bad   = 0;

    hardroc_readout_ctrl #(.DATA_WIDTH(16), .START_PULSE_LEN(4)) dut (
        .Clk               (Clk),
        .reset_n           (reset_n),
        .StartReadout      (StartReadout),
        .TRANSMITON        (TRANSMITON),
        .DOUT              (DOUT),
        .FifoFull          (FifoFull),
        .TimeoutCycles     (TimeoutCycles),
        .START_READOUT     (START_READOUT),
        .EndReadout        (EndReadout),
        .ParallelData      (ParallelData),
        .ParallelDataValid (ParallelDataValid),
        .WordCount         (WordCount),
        .ReadoutTimeout    (ReadoutTimeout),
        .FifoOverflow      (FifoOverflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Monitor: records strobed words, EndReadout pulses and strobe run lengths.
    logic [15:0] vw [0:63];
    int  n_valid = 0;
    int  n_end   = 0;
    int  end_run = 0;
    int  end_len = 0;
    int  sr_run  = 0;
    int  sr_len  = 0;
    time end_t   = 0;
    logic end_prev = 1'b0;

    always @(negedge Clk) begin
        if (ParallelDataValid) begin
            vw[n_valid % 64] <= ParallelData;
            n_valid <= n_valid + 1;
        end
        if (EndReadout) begin
            end_run <= end_run + 1;
            if (!end_prev) begin
                n_end <= n_end + 1;
                end_t <= $time;
            end
        end else if (end_run != 0) begin
            end_len <= end_run;
            end_run <= 0;
        end
        end_prev <= EndReadout;
        if (START_READOUT) begin
            sr_run <= sr_run + 1;
        end else if (sr_run != 0) begin
            sr_len <= sr_run;
            sr_run <= 0;
        end
    end

    typedef struct {
        logic [31:0] bits;   // serial stream, left-aligned, sent MSB first
        int          nbits;
        bit          ff2;    // FifoFull high from bit 16 onward
        bit          inj;    // stray StartReadout pulses during SHIFT
        logic [15:0] w0;
        logic [15:0] w1;
        int          nv;
        logic [15:0] wc;
        bit          ov;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic start_and_wait_strobe();
        @(negedge Clk);
        StartReadout = 1'b1;
        @(negedge Clk);
        StartReadout = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clk);
            if (!START_READOUT) break;
        end
    endtask

    task automatic wait_end(input int base, input int bound);
        for (int k = 0; k < bound; k++) begin
            @(negedge Clk);
            if (n_end != base) break;
        end
        repeat (3) @(negedge Clk);
    endtask

    task automatic run_and_check(input vec_t v, input string tag);
        int bv;
        int be;
        bv = n_valid;
        be = n_end;
        start_and_wait_strobe();
        for (int i = 0; i < v.nbits; i++) begin
            TRANSMITON   = 1'b1;
            DOUT         = v.bits[31 - i];
            FifoFull     = v.ff2 && (i >= 16);
            StartReadout = v.inj && (i == 5 || i == 20);
            @(negedge Clk);
        end
        TRANSMITON   = 1'b0;
        DOUT         = 1'b0;
        StartReadout = 1'b0;
        repeat (2) @(negedge Clk);
        FifoFull = 1'b0;
        wait_end(be, 100);
        chk({tag, "_sr_len"},  sr_len, 4);
        chk({tag, "_n_end"},   n_end - be, 1);
        chk({tag, "_end_len"}, end_len, 1);
        chk({tag, "_n_valid"}, n_valid - bv, v.nv);
        if (v.nv >= 1) chk({tag, "_w0"}, vw[bv % 64], v.w0);
        if (v.nv >= 2) chk({tag, "_w1"}, vw[(bv + 1) % 64], v.w1);
        chk({tag, "_wcount"},   WordCount, v.wc);
        chk({tag, "_overflow"}, FifoOverflow, v.ov);
        chk({tag, "_timeout"},  ReadoutTimeout, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int  bv;
        int  be;
        time st;
        int  lat;

        tbl[0] = '{32'hA5C30F0F, 32, 1'b0, 1'b0, 16'hA5C3, 16'h0F0F, 2, 16'd2, 1'b0};
        tbl[1] = '{32'hFFFFB000, 20, 1'b0, 1'b0, 16'hFFFF, 16'hB000, 2, 16'd2, 1'b0};
        tbl[2] = '{32'hA5C30F0F, 32, 1'b1, 1'b0, 16'hA5C3, 16'h0000, 1, 16'd1, 1'b1};
        tbl[3] = '{32'h80000000,  1, 1'b0, 1'b0, 16'h8000, 16'h0000, 1, 16'd1, 1'b0};
        tbl[4] = '{32'h12340000, 16, 1'b0, 1'b0, 16'h1234, 16'h0000, 1, 16'd1, 1'b0};
        tbl[5] = '{32'hA5C30F0F, 32, 1'b0, 1'b1, 16'hA5C3, 16'h0F0F, 2, 16'd2, 1'b0};

        reset_n       = 1'b0;
        StartReadout  = 1'b1;
        TRANSMITON    = 1'b0;
        DOUT          = 1'b0;
        FifoFull      = 1'b0;
        TimeoutCycles = 16'd0;

        // Reset state, with StartReadout held during reset.
        repeat (3) @(negedge Clk);
        chk("reset_flags", {START_READOUT, EndReadout, ParallelDataValid, ReadoutTimeout, FifoOverflow}, 5'b0);
        chk("reset_pdata", ParallelData, 16'h0000);
        chk("reset_wcount", WordCount, 16'h0000);
        StartReadout = 1'b0;
        reset_n      = 1'b1;
        repeat (3) @(negedge Clk);
        chk("start_during_reset_ignored", START_READOUT, 1'b0);

        for (int t = 0; t < 6; t++) begin
            run_and_check(tbl[t], $sformatf("vec%0d", t));
        end

        // Timeout with TRANSMITON never rising.
        TimeoutCycles = 16'd50;
        bv = n_valid;
        be = n_end;
        @(negedge Clk);
        StartReadout = 1'b1;
        st = $time;
        @(negedge Clk);
        StartReadout = 1'b0;
        wait_end(be, 200);
        lat = int'((end_t - st) / 10);
        chk("tmo_n_end", n_end - be, 1);
        chk("tmo_latency_in_range", (lat >= 48 && lat <= 58), 1'b1);
        chk("tmo_flag", ReadoutTimeout, 1'b1);
        chk("tmo_no_valid", n_valid - bv, 0);
        chk("tmo_wcount", WordCount, 16'd0);
        TimeoutCycles = 16'd0;
        run_and_check(tbl[0], "after_tmo");

        // Reset mid-SHIFT: outputs cleared, no EndReadout, then a normal readout.
        bv = n_valid;
        be = n_end;
        start_and_wait_strobe();
        for (int i = 0; i < 8; i++) begin
            TRANSMITON = 1'b1;
            DOUT       = tbl[0].bits[31 - i];
            @(negedge Clk);
        end
        reset_n    = 1'b0;
        TRANSMITON = 1'b0;
        @(negedge Clk);
        chk("midrst_flags", {START_READOUT, EndReadout, ParallelDataValid, ReadoutTimeout, FifoOverflow}, 5'b0);
        chk("midrst_pdata", ParallelData, 16'h0000);
        chk("midrst_wcount", WordCount, 16'h0000);
        reset_n = 1'b1;
        repeat (10) @(negedge Clk);
        chk("midrst_no_end", n_end - be, 0);
        chk("midrst_no_valid", n_valid - bv, 0);
        run_and_check(tbl[1], "after_midrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
